// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with the sign correction applied when the result is written.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] MulDivResult
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r, state_nxt_s;
  logic [2:0]      op_r;
  logic [W-1:0]    opnd_r;
  logic [2*W-1:0]  acc_r, acc_nxt_s;
  logic            neg_a_r, neg_b_r, div_zero_r;
  logic [CW-1:0]   cnt_r;
  logic            signed_a_s, signed_b_s, sign_a_s, sign_b_s;
  logic [W-1:0]    a_mag_s, b_mag_s, res_s;
  logic [W:0]      add_s, rem_shift_s, diff_s;
  logic [2*W-1:0]  prod_s;
  logic            accept_s, iterate_s;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return {W{1'b0}} - x;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x);
    return {(2*W){1'b0}} - x;
  endfunction

  assign accept_s  = (state_r != CALC) && start && !flush;
  assign iterate_s = (state_r == CALC) && !flush;

  // Operand signedness per opcode and magnitudes taken at accept
  always_comb begin
    signed_a_s = 1'b0;
    signed_b_s = 1'b0;
    case (Funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin signed_a_s = 1'b1; signed_b_s = 1'b1; end
      3'b010:                         begin signed_a_s = 1'b1; signed_b_s = 1'b0; end
      default:                        begin signed_a_s = 1'b0; signed_b_s = 1'b0; end
    endcase
  end

  assign sign_a_s = SrcA[W-1] & signed_a_s;
  assign sign_b_s = SrcB[W-1] & signed_b_s;
  assign a_mag_s  = sign_a_s ? neg_w(SrcA) : SrcA;
  assign b_mag_s  = sign_b_s ? neg_w(SrcB) : SrcB;

  // acc holds {high, multiplier} for multiply and {remainder, quotient} for divide
  assign add_s       = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
  assign rem_shift_s = acc_r[2*W-1:W-1];
  assign diff_s      = rem_shift_s - {1'b0, opnd_r};

  // One shift-add or shift-subtract step
  always_comb begin
    acc_nxt_s = acc_r;
    if (!op_r[2]) begin
      acc_nxt_s = {add_s, acc_r[W-1:1]};
    end else if (!diff_s[W]) begin
      acc_nxt_s = {diff_s[W-1:0], acc_r[W-2:0], 1'b1};
    end else begin
      acc_nxt_s = {rem_shift_s[W-1:0], acc_r[W-2:0], 1'b0};
    end
  end

  assign prod_s = (neg_a_r ^ neg_b_r) ? neg_2w(acc_nxt_s) : acc_nxt_s;

  // Final result selection with sign fix and divide-by-zero override
  always_comb begin
    res_s = {W{1'b0}};
    case (op_r)
      3'b000:                 res_s = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: res_s = prod_s[2*W-1:W];
      3'b100, 3'b101: begin
        if (div_zero_r) res_s = {W{1'b1}};
        else if (neg_a_r ^ neg_b_r) res_s = neg_w(acc_nxt_s[W-1:0]);
        else res_s = acc_nxt_s[W-1:0];
      end
      3'b110, 3'b111: begin
        if (neg_a_r) res_s = neg_w(acc_nxt_s[2*W-1:W]);
        else res_s = acc_nxt_s[2*W-1:W];
      end
      default:                res_s = {W{1'b0}};
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = CALC;
        else          state_nxt_s = IDLE;
      end
      CALC: begin
        if (flush)                  state_nxt_s = IDLE;
        else if (cnt_r == CW'(1))   state_nxt_s = DONE;
        else                        state_nxt_s = CALC;
      end
      DONE: begin
        if (accept_s) state_nxt_s = CALC;
        else          state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      CALC:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r         <= 3'b000;
      opnd_r       <= {W{1'b0}};
      acc_r        <= {(2*W){1'b0}};
      neg_a_r      <= 1'b0;
      neg_b_r      <= 1'b0;
      div_zero_r   <= 1'b0;
      cnt_r        <= {CW{1'b0}};
      MulDivResult <= {W{1'b0}};
    end else if (accept_s) begin
      op_r       <= Funct3;
      neg_a_r    <= sign_a_s;
      neg_b_r    <= sign_b_s;
      div_zero_r <= (SrcB == {W{1'b0}});
      cnt_r      <= CW'(W);
      opnd_r     <= Funct3[2] ? b_mag_s : a_mag_s;
      acc_r      <= {{W{1'b0}}, (Funct3[2] ? a_mag_s : b_mag_s)};
    end else if (iterate_s) begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_r - CW'(1);
      if (cnt_r == CW'(1)) MulDivResult <= res_s;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a countdown/arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] res;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .Funct3(funct3),
    .SrcA(src_a), .SrcB(src_b), .flush(flush),
    .busy(busy), .done(done), .MulDivResult(res)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // RISC-V M-extension arithmetic straight from the ISA rules
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 32'd0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 32'd0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // Model: remaining busy cycles, done flag and held result
  int          m_rem  = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = 32'd0;
  logic [31:0] m_pend = 32'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0; m_done = 1'b0; m_res = 32'd0;
    end else if (m_rem > 0) begin
      if (flush) m_rem = 0;
      else begin
        m_rem--;
        if (m_rem == 0) begin m_done = 1'b1; m_res = m_pend; end
      end
    end else begin
      m_done = 1'b0;
      if (start && !flush) begin m_rem = 32; m_pend = ref_op(funct3, src_a, src_b); end
    end
    #1;
    check("cyc_busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
    check("cyc_done", {31'd0, done}, {31'd0, m_done});
    check("cyc_result", res, m_res);
  end

  typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
  vec_t vecs[] = '{
    '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB},
    '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000},
    '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},
    '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},
    '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
    '{3'd5, 32'h00000005, 32'h00000000, 32'hFFFFFFFF},
    '{3'd7, 32'h00000005, 32'h00000000, 32'h00000005},
    '{3'd4, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF},
    '{3'd6, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9},
    '{3'd0, 32'h12345678, 32'h00000010, 32'h23456780},
    '{3'd1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF},
    '{3'd5, 32'h00000100, 32'h00000007, 32'h00000024},
    '{3'd7, 32'h00000100, 32'h00000007, 32'h00000004},
    '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD},
    '{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001}
  };

  // Called at a negedge; returns at the negedge where done is observed
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int n;
    funct3 = f3; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; funct3 = ~f3; src_a = $urandom; src_b = $urandom;
    check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, 33);
    check({name, "_result"}, res, exp);
  endtask

  initial begin
    logic [31:0] held;
    logic        saw_done;
    int          n;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", res, 32'd0);
    end

    foreach (vecs[i]) check($sformatf("model_vec%0d", i), ref_op(vecs[i].f3, vecs[i].a, vecs[i].b), vecs[i].exp);

    // First vector from IDLE, the rest back-to-back from DONE
    foreach (vecs[i]) run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    held = res;
    repeat (3) @(negedge clk);

    // Flush after ten CALC cycles
    funct3 = 3'd0; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin @(negedge clk); saw_done |= done; end
    check("flush_no_done", {31'd0, saw_done}, 32'd0);
    check("flush_held", res, held);

    // Start and flush together: request dropped
    start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check("flush_start_drop", {31'd0, busy}, 32'd0);

    // Start pulsed during CALC is ignored
    funct3 = 3'd0; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    funct3 = 3'd0; src_a = 32'd100; src_b = 32'd100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 6;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("calc_start_latency", n, 33);
    check("calc_start_result", res, 32'd15);
    @(negedge clk);
    check("calc_start_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of CALC
    run_op(3'd3, 32'h0000FFFF, 32'h00010000, 32'h00000000, "pre_reset");
    funct3 = 3'd4; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", res, 32'd0);
    repeat (40) @(negedge clk);
    check("midrst_quiet", {31'd0, done | busy}, 32'd0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
